// File: rtl/systolic_pkg.sv
// Shared types and sizing for the 2x2 systolic array sequencer.
// The FSM walks one job at a time from operand load through result handoff.
package systolic_pkg;

   localparam int DW       = 8;
   localparam int AW       = 16;
   localparam int FEED_CYC = 3;
   localparam int STEP_W   = 3;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      FEED    = 3'd2,
      DRAIN   = 3'd3,
      CAPTURE = 3'd4,
      RESULT  = 3'd5
   } state_e;

endpackage

// File: rtl/wavefront_feeder.sv
// Holds the latched A,B operands and drives the skewed west/north wavefronts.
// Outputs are registered from the controller's next step so they line up with FEED cycles.
module wavefront_feeder #(
   parameter int DW = systolic_pkg::DW
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               load,
   input  logic [4*DW-1:0]                    a_flat,
   input  logic [4*DW-1:0]                    b_flat,
   input  logic                               feed_en,
   input  logic [systolic_pkg::STEP_W-1:0]    step,
   output logic [DW-1:0]                      a_row0,
   output logic [DW-1:0]                      a_row1,
   output logic [DW-1:0]                      b_col0,
   output logic [DW-1:0]                      b_col1
);
   import systolic_pkg::*;

   logic [4*DW-1:0] a_hold_q, a_hold_d;
   logic [4*DW-1:0] b_hold_q, b_hold_d;
   logic signed [DW-1:0] a_row0_q, a_row0_d;
   logic signed [DW-1:0] a_row1_q, a_row1_d;
   logic signed [DW-1:0] b_col0_q, b_col0_d;
   logic signed [DW-1:0] b_col1_q, b_col1_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_hold_q <= '0;
         b_hold_q <= '0;
         a_row0_q <= '0;
         a_row1_q <= '0;
         b_col0_q <= '0;
         b_col1_q <= '0;
      end else begin
         a_hold_q <= a_hold_d;
         b_hold_q <= b_hold_d;
         a_row0_q <= a_row0_d;
         a_row1_q <= a_row1_d;
         b_col0_q <= b_col0_d;
         b_col1_q <= b_col1_d;
      end
   end

   // Row 1 / column 1 lag row 0 / column 0 by one step to form the diagonal wavefront.
   always_comb begin
      a_hold_d = load ? a_flat : a_hold_q;
      b_hold_d = load ? b_flat : b_hold_q;
      a_row0_d = '0;
      a_row1_d = '0;
      b_col0_d = '0;
      b_col1_d = '0;
      if (feed_en) begin
         case (step)
            STEP_W'(0): begin
               a_row0_d = a_hold_q[0*DW +: DW];
               b_col0_d = b_hold_q[0*DW +: DW];
            end
            STEP_W'(1): begin
               a_row0_d = a_hold_q[1*DW +: DW];
               a_row1_d = a_hold_q[2*DW +: DW];
               b_col0_d = b_hold_q[2*DW +: DW];
               b_col1_d = b_hold_q[1*DW +: DW];
            end
            STEP_W'(2): begin
               a_row1_d = a_hold_q[3*DW +: DW];
               b_col1_d = b_hold_q[3*DW +: DW];
            end
            default: begin
               a_row0_d = '0;
               a_row1_d = '0;
               b_col0_d = '0;
               b_col1_d = '0;
            end
         endcase
      end
   end

   assign a_row0 = a_row0_q;
   assign a_row1 = a_row1_q;
   assign b_col0 = b_col0_q;
   assign b_col1 = b_col1_q;

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for the 2x2 signed systolic array: accept A,B, clear, feed, flush,
// capture the accumulators and hold C until the consumer takes it.
module systolic_seq_ctrl #(
   parameter int DW        = systolic_pkg::DW,
   parameter int AW        = systolic_pkg::AW,
   parameter int DRAIN_CYC = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [4*DW-1:0] a_flat,
   input  logic [4*DW-1:0] b_flat,
   input  logic            abort,
   output logic            pe_clear,
   output logic            pe_enable,
   output logic [DW-1:0]   a_row0,
   output logic [DW-1:0]   a_row1,
   output logic [DW-1:0]   b_col0,
   output logic [DW-1:0]   b_col1,
   input  logic [4*AW-1:0] acc_flat,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [4*AW-1:0] c_flat,
   output logic            busy
);
   import systolic_pkg::*;

   localparam logic [STEP_W-1:0] FEED_LAST  = STEP_W'(FEED_CYC - 1);
   localparam logic [STEP_W-1:0] DRAIN_LAST = STEP_W'(DRAIN_CYC - 1);

   state_e             state_q, state_d;
   logic [STEP_W-1:0]  step_q, step_d;
   logic [4*AW-1:0]    c_flat_q, c_flat_d;
   logic               accept;
   logic               feed_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         step_q   <= '0;
         c_flat_q <= '0;
      end else begin
         state_q  <= state_d;
         step_q   <= step_d;
         c_flat_q <= c_flat_d;
      end
   end

   // The step counter restarts at zero on every state change, so it only counts within FEED/DRAIN.
   always_comb begin
      state_d  = state_q;
      step_d   = '0;
      c_flat_d = c_flat_q;
      accept   = req_valid && (state_q == IDLE);
      case (state_q)
         IDLE: begin
            if (accept) state_d = CLEAR;
         end
         CLEAR: begin
            state_d = FEED;
         end
         FEED: begin
            if (step_q == FEED_LAST) state_d = DRAIN;
            else                     step_d  = step_q + STEP_W'(1);
         end
         DRAIN: begin
            if (step_q == DRAIN_LAST) state_d = CAPTURE;
            else                      step_d  = step_q + STEP_W'(1);
         end
         CAPTURE: begin
            c_flat_d = acc_flat;
            state_d  = RESULT;
         end
         RESULT: begin
            if (res_ready) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Abort wins over every other transition and leaves the last captured result untouched.
      if (abort && (state_q != IDLE)) begin
         state_d  = IDLE;
         step_d   = '0;
         c_flat_d = c_flat_q;
      end
      feed_next = (state_d == FEED);
   end

   always_comb begin
      req_ready = 1'b0;
      busy      = 1'b1;
      pe_clear  = 1'b0;
      pe_enable = 1'b0;
      res_valid = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
         end
         CLEAR:   pe_clear  = 1'b1;
         FEED:    pe_enable = 1'b1;
         DRAIN:   pe_enable = 1'b1;
         CAPTURE: pe_enable = 1'b0;
         RESULT:  res_valid = 1'b1;
         default: busy      = 1'b1;
      endcase
   end

   assign c_flat = c_flat_q;

   wavefront_feeder #(
      .DW (DW)
   ) u_feeder (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (accept),
      .a_flat  (a_flat),
      .b_flat  (b_flat),
      .feed_en (feed_next),
      .step    (step_d),
      .a_row0  (a_row0),
      .a_row1  (a_row1),
      .b_col0  (b_col0),
      .b_col1  (b_col1)
   );

endmodule
